// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, one full-adder slice, LSB first,
//            start/done handshake. Optional subtract mode: SERIAL_ADDER_SUB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_res;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_cout;
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_fa_sum;
  logic                 w_fa_carry;
  logic [WIDTH-1:0]     w_b_load;
  logic                 w_c_load;

  // Subtraction is a + ~b + 1: invert b once at capture and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  // Single full-adder slice operating on the current LSBs and the carry flop.
  assign w_fa_sum   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_fa_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
      r_res   <= {w_fa_sum, r_res[WIDTH-1:1]};
      r_carry <= w_fa_carry;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= {w_fa_sum, r_res[WIDTH-1:1]};
        r_cout <= w_fa_carry;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder (WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone = 0;
  int npush = 0;
  int busy_cnt = 0;
  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic s);
    logic [WIDTH:0] e;
    if (s) e = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else   e = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    npush++;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic s);
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    @(posedge clk);
    #1;
    push_exp(x, y, ci, s);
    start = 1'b0;
  endtask

  task automatic wait_quiet();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("quiet_timeout", ok, 1'b1);
  endtask

  task automatic wait_done(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard: every done pops one expectation; done must land in the
  // (WIDTH+1)-th cycle after the accepting edge, after WIDTH busy cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        ndone++;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 1'b1, 1'b0);
        end else begin
          logic [WIDTH:0] e;
          int             t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          chk("result", {cout, sum}, e);
          chk("latency", cyc - t, WIDTH);
          chk("busy_len", busy_cnt, WIDTH);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   t1;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    start_op(8'h5A, 8'h33, 1'b0, 1'b0);
    wait_quiet();
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_quiet();
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_quiet();

    // Start pulse in the middle of RUN must be ignored.
    start_op(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet();

    // Back-to-back: start held through DONE.
    start_op(8'h40, 8'h04, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    wait_done(found);
    chk("b2b_first_done", found, 1'b1);
    chk("b2b_busy_in_done", busy, 1'b0);
    t1 = cyc;
    @(posedge clk);
    #1;
    push_exp(8'h01, 8'h02, 1'b0, 1'b0);
    start = 1'b0;
    chk("b2b_busy_rerun", busy, 1'b1);
    wait_done(found);
    chk("b2b_second_done", found, 1'b1);
    chk("b2b_spacing", cyc - t1, WIDTH + 1);
    wait_quiet();

    // Reset mid-RUN aborts with no done pulse.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {busy, done}, 2'b00);
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_quiet();

    // Random operands, scrambled inputs during RUN must not matter.
    for (int i = 0; i < 6; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      wait_quiet();
    end

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    wait_quiet();
    start_op(8'h20, 8'h10, 1'b0, 1'b1);
    wait_quiet();
    start_op(8'h33, 8'h33, 1'b0, 1'b1);
    wait_quiet();
    start_op(8'h12, 8'h34, 1'b1, 1'b0);
    wait_quiet();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("done_count", ndone, npush);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
